// File: rtl/data_cache_controller_pkg.sv
// Shared widths, controller state encodings and byte-select helper for the
// direct-mapped data cache.
package data_cache_controller_pkg;

  localparam int unsigned TAG_W    = 3;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned BLOCK_W  = 32;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] FETCH     = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  // Byte 0 sits in bits [7:0], byte 3 in bits [31:24], same as memory.
  function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0]  block,
                                             input logic [OFFSET_W-1:0] offset);
    return block[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/data_cache_controller_cache_line_store.sv
// Line storage: data/tag arrays (never cleared) plus valid/dirty bits
// (asynchronously cleared). One byte-write port, one block-fill port and a
// combinational read of the indexed line.
module cache_line_store
  import data_cache_controller_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  index,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_offset,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data,
  output logic [BLOCK_W-1:0]  line_data,
  output logic [TAG_W-1:0]    line_tag,
  output logic                line_valid,
  output logic                line_dirty
);

  logic [BLOCK_W-1:0]   data [NUM_LINES];
  logic [TAG_W-1:0]     tag  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  // Status bits: cleared on reset, set valid/clean on fill, dirty on a byte write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_we) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (byte_we) begin
      dirty[index] <= 1'b1;
    end
  end

  // Payload arrays: whole-block fill with new tag, or a single byte update.
  always_ff @(posedge clock) begin
    if (fill_we) begin
      data[index] <= fill_data;
      tag[index]  <= fill_tag;
    end else if (byte_we) begin
      data[index][{byte_offset, 3'b000} +: 8] <= byte_data;
    end
  end

  assign line_data  = data[index];
  assign line_tag   = tag[index];
  assign line_valid = valid[index];
  assign line_dirty = dirty[index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller between the
// 8-bit CPU load/store port and a 32-bit word memory. Hits complete with no
// stall; misses stall the CPU through WRITEBACK (dirty victim), FETCH, UPDATE.
module data_cache_controller
  import data_cache_controller_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          address,
  input  logic [7:0]                 writedata,
  output logic [7:0]                 readdata,
  output logic                       busywait,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-OFFSET_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]         mem_writedata,
  input  logic [BLOCK_W-1:0]         mem_readdata,
  input  logic                       mem_busywait
);

  state_t               state;
  logic                 issued;
  logic [BLOCK_W-1:0]   fill_buf;

  logic [TAG_W-1:0]     cpu_tag;
  logic [INDEX_W-1:0]   cpu_index;
  logic [OFFSET_W-1:0]  cpu_offset;
  logic                 request;
  logic                 request_read;
  logic                 request_write;
  logic                 hit;

  logic [BLOCK_W-1:0]   line_data;
  logic [TAG_W-1:0]     line_tag;
  logic                 line_valid;
  logic                 line_dirty;

  assign cpu_tag    = address[ADDR_W-1 -: TAG_W];
  assign cpu_index  = address[OFFSET_W +: INDEX_W];
  assign cpu_offset = address[OFFSET_W-1:0];

  // Read and write together is treated as no request at all.
  assign request       = read ^ write;
  assign request_read  = read & ~write;
  assign request_write = write & ~read;
  assign hit           = line_valid && (line_tag == cpu_tag);

  cache_line_store #(
    .NUM_LINES(NUM_LINES)
  ) u_store (
    .clock      (clock),
    .reset      (reset),
    .index      (cpu_index),
    .byte_we    (state == IDLE && request_write && hit),
    .byte_offset(cpu_offset),
    .byte_data  (writedata),
    .fill_we    (state == UPDATE),
    .fill_tag   (cpu_tag),
    .fill_data  (fill_buf),
    .line_data  (line_data),
    .line_tag   (line_tag),
    .line_valid (line_valid),
    .line_dirty (line_dirty)
  );

  // CPU side: combinational hit data, stall for any legal request that misses.
  always_comb begin
    readdata = '0;
    busywait = 1'b0;
    if (!reset && request && !hit) busywait = 1'b1;
    if (request_read && hit)       readdata = select_byte(line_data, cpu_offset);
  end

  // Memory side: requests and address/data derived purely from state, so they
  // hold steady for the whole transaction while the CPU holds its inputs.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {line_tag, cpu_index};
        mem_writedata = line_data;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = address[ADDR_W-1:OFFSET_W];
      end
      default: ;
    endcase
  end

  // Miss handling FSM. 'issued' keeps a memory transaction from completing on
  // the same edge it is first presented, before memory has seen it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      issued   <= 1'b0;
      fill_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          issued <= 1'b0;
          if (request && !hit) state <= (line_valid && line_dirty) ? WRITEBACK : FETCH;
        end
        WRITEBACK: begin
          if (!issued) issued <= 1'b1;
          else if (!mem_busywait) begin
            state  <= FETCH;
            issued <= 1'b0;
          end
        end
        FETCH: begin
          if (!issued) issued <= 1'b1;
          else if (!mem_busywait) begin
            state    <= UPDATE;
            issued   <= 1'b0;
            fill_buf <= mem_readdata;
          end
        end
        UPDATE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomised scoreboard bench for data_cache_controller: a behavioural cache
// model predicts every CPU response and memory transaction; a negedge monitor
// compares whatever the DUT presents against the queued predictions.
module tb_data_cache_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  data_cache_controller #(.NUM_LINES(8), .ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { bit wr; logic [5:0] addr; logic [31:0] data; } mem_txn_t;
  typedef struct { bit rd; logic [7:0] data; bit hit; } acc_t;

  mem_txn_t exp_mem[$];
  acc_t     exp_acc[$];

  // Memory contents as the outside world sees them, and the model's copy.
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_data[8];
  logic [2:0]  ref_tag [8];
  bit          ref_valid[8];
  bit          ref_dirty[8];

  // Behavioural cache: decide hit/miss, emit the memory traffic a miss needs,
  // then perform the access on the (now resident) line.
  function automatic void ref_access(bit rd, logic [7:0] a, logic [7:0] wd);
    int unsigned idx = a[4:2];
    int unsigned off = a[1:0];
    logic [2:0]  tg  = a[7:5];
    bit          hit;
    mem_txn_t    t;
    acc_t        e;
    hit = ref_valid[idx] && ref_tag[idx] == tg;
    if (!hit) begin
      if (ref_valid[idx] && ref_dirty[idx]) begin
        t.wr = 1'b1; t.addr = {ref_tag[idx], 3'(idx)}; t.data = ref_data[idx];
        exp_mem.push_back(t);
        ref_mem[t.addr] = ref_data[idx];
      end
      t.wr = 1'b0; t.addr = a[7:2]; t.data = '0;
      exp_mem.push_back(t);
      ref_data[idx]  = ref_mem[a[7:2]];
      ref_tag[idx]   = tg;
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
    end
    e.rd = rd; e.hit = hit; e.data = '0;
    if (rd) e.data = ref_data[idx][off*8 +: 8];
    else begin
      ref_data[idx][off*8 +: 8] = wd;
      ref_dirty[idx] = 1'b1;
    end
    exp_acc.push_back(e);
  endfunction

  function automatic void ref_reset();
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endfunction

  // Memory responder: accepts a request, stays busy 1..4 cycles, completes,
  // then ignores the still-asserted request for one edge while the
  // controller moves on.
  bit          m_busy, m_cool, m_op;
  int          m_cnt;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  initial begin
    m_busy = 1'b0; m_cool = 1'b0; m_cnt = 0;
    mem_busywait = 1'b0;
    mem_readdata = '0;
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_busy = 1'b0; m_cool = 1'b0;
        mem_busywait <= 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy = 1'b0; m_cool = 1'b1;
          mem_busywait <= 1'b0;
          if (m_op) mem[m_addr] = m_data;
          else      mem_readdata <= mem[m_addr];
        end else m_cnt--;
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (mem_read || mem_write) begin
        m_busy = 1'b1; m_op = mem_write; m_addr = mem_address; m_data = mem_writedata;
        m_cnt = $urandom_range(0, 3);
        mem_busywait <= 1'b1;
      end
    end
  end

  // Monitor: checks memory transactions and CPU completions against queues.
  logic [1:0]  prev_req;
  logic [5:0]  hold_addr;
  logic [31:0] hold_wd;
  int          stall;

  initial begin
    mem_txn_t t;
    acc_t     e;
    prev_req = 2'b00; stall = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_req = 2'b00;
        stall = 0;
      end else begin
        check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        if ({mem_read, mem_write} != 2'b00 && {mem_read, mem_write} != prev_req) begin
          if (exp_mem.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_mem: got wr=%0d addr=0x%0h, required no request", mem_write, mem_address);
          end else begin
            t = exp_mem.pop_front();
            check("mem_op_is_write", 32'(mem_write), 32'(t.wr));
            check("mem_address", 32'(mem_address), 32'(t.addr));
            if (t.wr) check("mem_writedata", mem_writedata, t.data);
          end
          hold_addr = mem_address;
          hold_wd   = mem_writedata;
        end else if ({mem_read, mem_write} != 2'b00) begin
          check("mem_address_stable", 32'(mem_address), 32'(hold_addr));
          check("mem_writedata_stable", mem_writedata, hold_wd);
        end
        prev_req = {mem_read, mem_write};

        if (read ^ write) begin
          if (busywait) stall++;
          else begin
            if (exp_acc.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_completion: got completion at 0x%0h, required none", address);
            end else begin
              e = exp_acc.pop_front();
              check("access_no_stall_iff_hit", 32'(stall == 0), 32'(e.hit));
              if (e.rd) check("readdata", 32'(readdata), 32'(e.data));
            end
            stall = 0;
          end
        end else begin
          check("busywait_without_request", 32'(busywait), 32'd0);
        end
      end
    end
  end

  task automatic do_access(bit rd, logic [7:0] a, logic [7:0] wd);
    int cyc = 0;
    ref_access(rd, a, wd);
    read = rd; write = !rd; address = a; writedata = wd;
    do begin
      @(negedge clock);
      cyc++;
    end while (busywait && cyc < 100);
    if (busywait) begin
      tests++; fails++;
      $display("FAIL access_timeout: busywait still 1 after %0d cycles at 0x%0h, required 0", cyc, a);
    end
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] w;
    logic [7:0]  a;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    mem[0] = 32'h44332211;
    ref_mem[0] = 32'h44332211;
    ref_reset();

    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (2) @(posedge clock);
    #2;
    read = 1'b1;  // a held request must not raise busywait while in reset
    #1;
    check("reset_busywait", 32'(busywait), 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    check("reset_readdata", 32'(readdata), 32'd0);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    check("reset_mem_writedata", mem_writedata, 32'd0);
    read = 1'b0;
    reset = 1'b0;

    // Cold fill, hit in same line, write hit, dirty eviction, clean conflict.
    do_access(1'b1, 8'h00, 8'h00);
    do_access(1'b1, 8'h03, 8'h00);
    do_access(1'b0, 8'h01, 8'hAB);
    do_access(1'b1, 8'h01, 8'h00);
    do_access(1'b1, 8'h20, 8'h00);
    do_access(1'b1, 8'h44, 8'h00);
    do_access(1'b1, 8'h24, 8'h00);

    // Reset in the middle of a fetch drops everything at once.
    ref_access(1'b1, 8'h48, 8'h00);
    read = 1'b1; write = 1'b0; address = 8'h48;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!mem_read && cyc < 20);
    check("fetch_started", 32'(mem_read), 32'd1);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busywait", 32'(busywait), 32'd0);
    check("abort_mem_read", 32'(mem_read), 32'd0);
    check("abort_mem_write", 32'(mem_write), 32'd0);
    read = 1'b0;
    void'(exp_acc.pop_back());
    ref_reset();
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    do_access(1'b1, 8'h48, 8'h00);

    // Dirty every index with tag 0, then evict each with a different tag.
    for (int i = 0; i < 8; i++)
      do_access(1'b0, {3'b000, 3'(i), 2'($urandom_range(0, 3))}, 8'($urandom));
    for (int i = 0; i < 8; i++)
      do_access(1'b1, {3'($urandom_range(1, 7)), 3'(i), 2'($urandom_range(0, 3))}, 8'h00);

    // Random mix, tags limited so hits are common; occasional illegal read+write.
    for (int n = 0; n < 300; n++) begin
      a = {3'($urandom_range(0, 2)), 5'($urandom)};
      if ($urandom_range(0, 9) == 0) begin
        read = 1'b1; write = 1'b1; address = a; writedata = 8'($urandom);
        @(negedge clock);
        @(posedge clock);
        #1;
        read = 1'b0; write = 1'b0;
      end else begin
        do_access($urandom_range(0, 1) == 1, a, 8'($urandom));
      end
    end

    repeat (5) @(negedge clock);
    check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    check("access_queue_drained", 32'(exp_acc.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
